// File: rtl/sub32_serial.sv
// sub32_serial: digit-serial 32-bit subtractor computing a + ~b + 1, one 4-bit digit per cycle.
// Reports the result with unsigned borrow and signed overflow via a three-state FSM.
module sub32_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             borrow,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nxt;
    logic [2:0]       cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q, nb_q, work, work_nxt;
    logic [4:0]       idx;
    logic [DIGIT:0]   sum;
    logic             accept, last;
    assign accept = start && (state != RUN);
    assign last   = cnt == 3'd7;
    assign idx    = {cnt, 2'b00};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    end
    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end
    // Current digit sum; the work register gets this digit replaced in place.
    always_comb begin
        sum = {1'b0, a_q[idx +: DIGIT]} + {1'b0, nb_q[idx +: DIGIT]} + {{DIGIT{1'b0}}, carry};
        work_nxt = work;
        work_nxt[idx +: DIGIT] = sum[DIGIT-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            nb_q     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            work     <= '0;
            r        <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            nb_q  <= ~b;
            cnt   <= '0;
            carry <= 1'b1;
        end else if (state == RUN) begin
            work  <= work_nxt;
            carry <= sum[DIGIT];
            cnt   <= cnt + 3'd1;
            if (last) begin
                r        <= work_nxt;
                borrow   <= ~sum[DIGIT];
                overflow <= (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1]) & (a_q[WIDTH-1] ^ work_nxt[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_sub32_serial.sv
// tb_sub32_serial: directed and random checks of sub32_serial results, latency and reset behaviour.
module tb_sub32_serial;
    logic        clk = 0, rst_n = 0, start = 0;
    logic [31:0] a = 0, b = 0;
    logic        busy, done, borrow, overflow;
    logic [31:0] r;
    int          checks = 0, failures = 0;
    sub32_serial dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .r(r), .borrow(borrow), .overflow(overflow)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] d;
        d = x - y;
        return {x < y, (x[31] ^ y[31]) & (x[31] ^ d[31]), d};
    endfunction
    task automatic run_op(input logic [31:0] x, input logic [31:0] y);
        logic [33:0] m;
        m = model(x, y);
        @(negedge clk);
        a = x; b = y; start = 1;
        @(posedge clk); #1;
        start = 0; a = ~x; b = x ^ y;
        for (int i = 0; i < 8; i++) begin
            check("busy_run", {busy, done}, 2'b10);
            @(posedge clk); #1;
        end
        check("done_pulse", {busy, done}, 2'b01);
        check("result", {borrow, overflow, r}, m);
        @(posedge clk); #1;
        check("done_drop", {busy, done}, 2'b00);
        check("result_hold", {borrow, overflow, r}, m);
    endtask
    initial begin
        logic [31:0] xs [$], ys [$];
        logic [31:0] corner [4];
        logic [31:0] ra, rb;
        logic [33:0] m;
        corner = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        #3;
        check("reset_out", {busy, done, borrow, overflow, r}, '0);
        @(negedge clk); rst_n = 1;
        run_op(5, 3);
        check("r_5_3", r, 32'h2);
        run_op(3, 5);
        check("r_3_5", {borrow, overflow, r}, {2'b10, 32'hFFFFFFFE});
        run_op(0, 0);
        check("r_0_0", {borrow, overflow, r}, '0);
        run_op(32'h80000000, 1);
        check("ovf_neg", {borrow, overflow, r}, {2'b01, 32'h7FFFFFFF});
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF);
        check("ovf_pos", {borrow, overflow, r}, {2'b11, 32'h80000000});
        foreach (corner[i]) foreach (corner[j]) run_op(corner[i], corner[j]);
        // start held high with operands changing every cycle: only acceptance edges count
        for (int c = 0; c < 9 * 6; c++) begin
            @(negedge clk);
            start = 1; a = $urandom; b = $urandom;
            if (c % 9 == 0) begin xs.push_back(a); ys.push_back(b); end
            @(posedge clk); #1;
            if (c % 9 == 8) begin
                m = model(xs.pop_front(), ys.pop_front());
                check("b2b_done", {busy, done}, 2'b01);
                check("b2b_result", {borrow, overflow, r}, m);
            end else begin
                check("b2b_busy", {busy, done}, 2'b10);
            end
        end
        @(negedge clk); start = 0;
        @(posedge clk); #1;
        check("b2b_idle", {busy, done}, 2'b00);
        // asynchronous reset at RUN step 4
        run_op(32'h12345678, 32'h00000001);
        @(negedge clk); a = 32'hAAAA5555; b = 32'h1111; start = 1;
        @(posedge clk); #1; start = 0;
        repeat (4) @(posedge clk);
        #3 rst_n = 0;
        #1 check("abort_out", {busy, done, borrow, overflow, r}, '0);
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("abort_nodone", {busy, done, r}, '0);
        end
        run_op(32'hAAAA5555, 32'h1111);
        check("after_abort", r, 32'hAAAA4444);
        for (int k = 0; k < 2000; k++) begin
            ra = (k % 7 == 0) ? corner[k % 4] : $urandom;
            rb = (k % 5 == 0) ? corner[(k / 5) % 4] : $urandom;
            run_op(ra, rb);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
